data_memory_bytewise: RTL and testbench

Parametrised successor to the team's single-port word memory, used as CPU data memory. Adds a byte-enabled write path, a ready/valid request handshake and a registered read with a response strobe. Also adds address error detection and a hardware clear sequence after reset. Sits between the CPU load/store stage and the memory array; byte-addressed, word-aligned accesses.

---
 rtl/data_memory_bytewise_pkg.sv | 23 ++
 rtl/data_memory_bytewise_if.sv | 26 ++
 rtl/data_memory_bytewise.sv | 111 +++++++++++
 tb/tb_data_memory_bytewise.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_bytewise_pkg.sv
// Shared state type and elaboration-time helpers for the byte-enabled data memory.
package data_memory_pkg;

   typedef enum logic {INIT, READY} memState_e;

   function automatic int bytesPerWord(input int dataWidth);
      return dataWidth / 8;
   endfunction

   function automatic int offsetBits(input int dataWidth);
      return $clog2(dataWidth / 8);
   endfunction

   // Every word of the array must be reachable by a byte address.
   function automatic bit paramsLegal(input int dataWidth, input int addrWidth, input int depth);
      longint capacity;
      capacity = longint'(1) << addrWidth;
      return (dataWidth >= 8) && (dataWidth % 8 == 0) && (depth >= 1) &&
             (addrWidth >= 1) && (addrWidth <= 32) &&
             (longint'(depth) * longint'(dataWidth / 8) <= capacity);
   endfunction

endpackage

// File: rtl/data_memory_bytewise_if.sv
// Request/response bus between the CPU load/store stage and the data memory.
interface data_memory_bytewise_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [ADDR_WIDTH-1:0]     address;
   logic [DATA_WIDTH-1:0]     write_data;
   logic [DATA_WIDTH/8-1:0]   byte_enable;
   logic                      read_valid;
   logic [DATA_WIDTH-1:0]     read_data;
   logic                      error;
   logic                      init_done;

   modport master (
      output req_valid, req_write, address, write_data, byte_enable,
      input  req_ready, read_valid, read_data, error, init_done
   );

   modport slave (
      input  req_valid, req_write, address, write_data, byte_enable,
      output req_ready, read_valid, read_data, error, init_done
   );
endinterface

// File: rtl/data_memory_bytewise.sv
// Word-organised data memory with byte-enabled writes, registered reads, address
// error detection and a zero-clear sweep of the whole array after every reset.
module data_memory_bytewise
   import data_memory_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 64
) (
   input logic                   clock,
   input logic                   reset,
   data_memory_bytewise_if.slave bus
);

   localparam int BYTES       = bytesPerWord(DATA_WIDTH);
   localparam int OFFSET_BITS = offsetBits(DATA_WIDTH);
   localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
   localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(DEPTH - 1);

   if (!paramsLegal(DATA_WIDTH, ADDR_WIDTH, DEPTH)) begin : gBadParams
      $error("data_memory_bytewise: illegal DATA_WIDTH/ADDR_WIDTH/DEPTH combination");
   end

   memState_e               state_q, state_d;
   logic [IDX_W-1:0]        clearCount_q, clearCount_d;
   logic                    readValid_q, readValid_d;
   logic                    error_q, error_d;
   logic [DATA_WIDTH-1:0]   readData_q, readData_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0]   wordIdx;
   logic [IDX_W-1:0]        reqIdx;
   logic                    misaligned;
   logic                    outOfRange;
   logic                    reqError;
   logic                    accept;
   logic                    writeEn;

   // The range test is done on the full word index so high addresses never alias.
   assign wordIdx    = bus.address >> OFFSET_BITS;
   assign reqIdx     = wordIdx[IDX_W-1:0];
   assign misaligned = (bus.address & ALIGN_MASK) != '0;
   assign outOfRange = {1'b0, wordIdx} >= (ADDR_WIDTH + 1)'(DEPTH);
   assign reqError   = misaligned | outOfRange;
   assign accept     = bus.req_valid & (state_q == READY);
   assign writeEn    = accept & bus.req_write & ~reqError;

   assign bus.req_ready  = (state_q == READY);
   assign bus.init_done  = (state_q == READY);
   assign bus.read_valid = readValid_q;
   assign bus.read_data  = readData_q;
   assign bus.error      = error_q;

   always_comb begin
      state_d      = state_q;
      clearCount_d = clearCount_q;
      readValid_d  = 1'b0;
      error_d      = 1'b0;
      readData_d   = readData_q;
      unique case (state_q)
         INIT: begin
            clearCount_d = clearCount_q + IDX_W'(1);
            if (clearCount_q == LAST_IDX) begin
               state_d      = READY;
               clearCount_d = '0;
            end
         end
         READY: begin
            if (accept) begin
               error_d = reqError;
               if (!bus.req_write) begin
                  readValid_d = 1'b1;
                  readData_d  = reqError ? '0 : mem_q[reqIdx];
               end
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= INIT;
         clearCount_q <= '0;
         readValid_q  <= 1'b0;
         error_q      <= 1'b0;
         readData_q   <= '0;
      end else begin
         state_q      <= state_d;
         clearCount_q <= clearCount_d;
         readValid_q  <= readValid_d;
         error_q      <= error_d;
         readData_q   <= readData_d;
      end
   end

   // The array itself has no reset; the INIT sweep zeroes it one word per cycle.
   always_ff @(posedge clock) begin
      if (state_q == INIT) begin
         mem_q[clearCount_q] <= '0;
      end else if (writeEn) begin
         for (int b = 0; b < BYTES; b++) begin
            if (bus.byte_enable[b]) begin
               mem_q[reqIdx][8*b +: 8] <= bus.write_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_memory_bytewise.sv
// Bench for data_memory_bytewise: a 64-word and a 32-word instance share one stimulus
// stream and are tracked by a word-array model; a 64-bit instance gets directed checks.
module tb_data_memory_bytewise;

   typedef struct packed {
      logic        valid;
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        expRv;
      logic        expErr;
      logic        expErrC;
      logic [31:0] expData;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   data_memory_bytewise_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8))  busA ();
   data_memory_bytewise_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8))  busC ();
   data_memory_bytewise_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) busB ();

   assign busC.req_valid   = busA.req_valid;
   assign busC.req_write   = busA.req_write;
   assign busC.address     = busA.address;
   assign busC.write_data  = busA.write_data;
   assign busC.byte_enable = busA.byte_enable;

   data_memory_bytewise #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(64)) dutA (
      .clock(clock), .reset(reset), .bus(busA));
   data_memory_bytewise #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(32)) dutC (
      .clock(clock), .reset(reset), .bus(busC));
   data_memory_bytewise #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .DEPTH(128)) dutB (
      .clock(clock), .reset(reset), .bus(busB));

   logic [31:0] modelMem [2][64];
   int          initCount [2];
   logic        expValid [2];
   logic        expErr [2];
   logic [31:0] expData [2];
   int          edges = 0;
   int          vectors = 0;
   int          miscompares = 0;
   vec_t        vecs [25];

   function automatic int depthOf(input int d);
      return (d == 0) ? 64 : 32;
   endfunction

   task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Reference: an array of words, a cycle count since reset, and the address rules.
   task automatic stepModel(input int d);
      int depth;
      int idx;
      bit bad;
      depth = depthOf(d);
      if (!reset) begin
         initCount[d] = 0;
         expValid[d] = 1'b0;
         expErr[d] = 1'b0;
         expData[d] = 32'h0;
         for (int i = 0; i < 64; i++) modelMem[d][i] = 32'h0;
      end else begin
         expValid[d] = 1'b0;
         expErr[d] = 1'b0;
         if (busA.req_valid && initCount[d] >= depth) begin
            idx = int'(busA.address) / 4;
            bad = (int'(busA.address) % 4 != 0) || (idx >= depth);
            expErr[d] = bad;
            if (!busA.req_write) begin
               expValid[d] = 1'b1;
               expData[d] = bad ? 32'h0 : modelMem[d][idx];
            end else if (!bad) begin
               for (int b = 0; b < 4; b++)
                  if (busA.byte_enable[b]) modelMem[d][idx][8*b +: 8] = busA.write_data[8*b +: 8];
            end
         end
         if (initCount[d] < depth) initCount[d]++;
      end
   endtask

   task automatic checkOutput(input int d);
      string nm;
      logic rdy, done, rv, er;
      logic [31:0] rd;
      nm   = (d == 0) ? "A" : "C";
      rdy  = (d == 0) ? busA.req_ready  : busC.req_ready;
      done = (d == 0) ? busA.init_done  : busC.init_done;
      rv   = (d == 0) ? busA.read_valid : busC.read_valid;
      er   = (d == 0) ? busA.error      : busC.error;
      rd   = (d == 0) ? busA.read_data  : busC.read_data;
      compare({"model ", nm, " req_ready"},  rdy,  initCount[d] >= depthOf(d));
      compare({"model ", nm, " init_done"},  done, initCount[d] >= depthOf(d));
      compare({"model ", nm, " read_valid"}, rv,   expValid[d]);
      compare({"model ", nm, " error"},      er,   expErr[d]);
      compare({"model ", nm, " read_data"},  rd,   expData[d]);
   endtask

   task automatic setInputs(input logic valid, input logic wr, input logic [7:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
      busA.req_valid   = valid;
      busA.req_write   = wr;
      busA.address     = addr;
      busA.write_data  = wdata;
      busA.byte_enable = be;
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) edges++;
      else edges = 0;
      stepModel(0);
      stepModel(1);
      #1;
      checkOutput(0);
      checkOutput(1);
   endtask

   task automatic applyStimulus(input logic valid, input logic wr, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
      setInputs(valid, wr, addr, wdata, be);
      tick();
      @(negedge clock);
   endtask

   task automatic bCycle(input logic valid, input logic wr, input logic [9:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be);
      busB.req_valid   = valid;
      busB.req_write   = wr;
      busB.address     = addr;
      busB.write_data  = wdata;
      busB.byte_enable = be;
      applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      busB.req_valid   = 1'b0;
   endtask

   task automatic checkB(input string name, input logic rv, input logic er, input logic [63:0] data);
      compare({name, " read_valid"}, busB.read_valid, rv);
      compare({name, " error"},      busB.error,      er);
      compare({name, " read_data"},  busB.read_data,  data);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b1, 8'h04, 32'h2,        4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 1'b1, 8'h08, 32'h5,        4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 1'b1, 8'h0C, 32'h9,        4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 1'b1, 8'h18, 32'h7,        4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{1'b1, 1'b1, 8'h1C, 32'hA,        4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, 8'h18, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h7};
      vecs[7]  = '{1'b1, 1'b0, 8'h04, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h2};
      vecs[8]  = '{1'b1, 1'b0, 8'h1C, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'hA};
      vecs[9]  = '{1'b1, 1'b0, 8'h08, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h5};
      vecs[10] = '{1'b1, 1'b0, 8'h0C, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h9};
      vecs[11] = '{1'b1, 1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 1'b0, 32'h9};
      vecs[12] = '{1'b1, 1'b1, 8'h10, 32'h00001100, 4'h2, 1'b0, 1'b0, 1'b0, 32'h9};
      vecs[13] = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'hAABB11DD};
      vecs[14] = '{1'b1, 1'b1, 8'h10, 32'h12345678, 4'h0, 1'b0, 1'b0, 1'b0, 32'hAABB11DD};
      vecs[15] = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'hAABB11DD};
      vecs[16] = '{1'b1, 1'b0, 8'h06, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 32'h0};
      vecs[17] = '{1'b1, 1'b1, 8'h80, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0};
      vecs[18] = '{1'b1, 1'b0, 8'h80, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
      vecs[19] = '{1'b1, 1'b0, 8'h00, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[20] = '{1'b1, 1'b1, 8'h7C, 32'h11112222, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[21] = '{1'b1, 1'b0, 8'h7C, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h11112222};
      vecs[22] = '{1'b1, 1'b0, 8'hFC, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 32'h0};
      vecs[23] = '{1'b1, 1'b0, 8'h18, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h7};
      vecs[24] = '{1'b0, 1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 32'h7};

      setInputs(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      busB.req_valid = 1'b0;
      busB.req_write = 1'b0;
      busB.address = '0;
      busB.write_data = '0;
      busB.byte_enable = '0;

      // Power-on reset, then the clear sweep with a read held pending throughout.
      #1 reset = 1'b0;
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
      reset = 1'b1;
      while (!busA.req_ready && edges < 300) applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
      compare("A init length", edges, 64);

      for (int i = 0; i < 25; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
         compare($sformatf("vec%0d A read_valid", i), busA.read_valid, vecs[i].expRv);
         compare($sformatf("vec%0d A error", i), busA.error, vecs[i].expErr);
         compare($sformatf("vec%0d A read_data", i), busA.read_data, vecs[i].expData);
         compare($sformatf("vec%0d C error", i), busC.error, vecs[i].expErrC);
         compare($sformatf("vec%0d C read_data", i), busC.read_data,
                 (vecs[i].expErrC && vecs[i].valid && !vecs[i].wr) ? 32'h0 : vecs[i].expData);
      end

      // Wide instance: 8-byte alignment and the top word of a full 1 KiB space.
      while (!busB.req_ready && edges < 400) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
      compare("B init length", edges, 128);
      bCycle(1'b1, 1'b1, 10'h3F8, 64'h0123456789ABCDEF, 8'hFF);
      checkB("B write 3F8", 1'b0, 1'b0, 64'h0);
      bCycle(1'b1, 1'b0, 10'h3F8, 64'h0, 8'h00);
      checkB("B read 3F8", 1'b1, 1'b0, 64'h0123456789ABCDEF);
      bCycle(1'b1, 1'b0, 10'h00C, 64'h0, 8'h00);
      checkB("B read 00C", 1'b1, 1'b1, 64'h0);
      bCycle(1'b1, 1'b1, 10'h00C, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      checkB("B write 00C", 1'b0, 1'b1, 64'h0);
      bCycle(1'b1, 1'b0, 10'h008, 64'h0, 8'h00);
      checkB("B read 008 clean", 1'b1, 1'b0, 64'h0);
      bCycle(1'b1, 1'b1, 10'h008, 64'hCAFEF00D12345678, 8'hFF);
      checkB("B write 008", 1'b0, 1'b0, 64'h0);
      bCycle(1'b1, 1'b0, 10'h008, 64'h0, 8'h00);
      checkB("B read 008", 1'b1, 1'b0, 64'hCAFEF00D12345678);
      bCycle(1'b0, 1'b0, 10'h000, 64'h0, 8'h00);
      checkB("B idle hold", 1'b0, 1'b0, 64'hCAFEF00D12345678);

      for (int n = 0; n < 400; n++) begin
         logic [7:0] a;
         if ($urandom_range(0, 4) != 0) a = 8'($urandom_range(0, 63) * 4);
         else a = 8'($urandom_range(0, 255));
         applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom,
                       4'($urandom_range(0, 15)));
      end

      // Reset lands between edges while a read response is on the bus.
      setInputs(1'b1, 1'b0, 8'h04, 32'h0, 4'h0);
      tick();
      compare("pre-reset read_valid", busA.read_valid, 1'b1);
      #2 reset = 1'b0;
      #1;
      compare("async reset A read_valid", busA.read_valid, 1'b0);
      compare("async reset A error", busA.error, 1'b0);
      compare("async reset A read_data", busA.read_data, 32'h0);
      compare("async reset A req_ready", busA.req_ready, 1'b0);
      compare("async reset C read_valid", busC.read_valid, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, 8'h04, 32'h0, 4'h0);
      reset = 1'b1;
      while (!busA.req_ready && edges < 300) applyStimulus(1'b1, 1'b0, 8'h04, 32'h0, 4'h0);
      compare("A re-init length", edges, 64);
      applyStimulus(1'b1, 1'b0, 8'h04, 32'h0, 4'h0);
      compare("post-reset read_valid", busA.read_valid, 1'b1);
      compare("post-reset read_data", busA.read_data, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
